// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: word width, op codes and
// FSM state encodings.
package mdu_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int MDUOP_WIDTH = 3;

  // Encoding 0 and 5..7 are "no operation" and are ignored by the unit.
  localparam logic [MDUOP_WIDTH-1:0] MDU_OP_NONE  = 3'd0;
  localparam logic [MDUOP_WIDTH-1:0] MDU_OP_MULT  = 3'd1;
  localparam logic [MDUOP_WIDTH-1:0] MDU_OP_MULTU = 3'd2;
  localparam logic [MDUOP_WIDTH-1:0] MDU_OP_DIV   = 3'd3;
  localparam logic [MDUOP_WIDTH-1:0] MDU_OP_DIVU  = 3'd4;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic mdu_op_valid(input logic [MDUOP_WIDTH-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle shift datapath shared by multiply and divide.
// A single 2W-bit accumulator holds {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits;
//   divide:   upper = partial remainder, lower = dividend bits / quotient.
// Operands are unsigned magnitudes; sign handling lives in the top level.
module mdu_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc
);

  logic [W-1:0] opb;
  logic         mode_div;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_trial;

  // Step arithmetic: shift-add for multiply, W+1-bit trial subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = acc[2*W-1:W-1];
    div_trial = div_shift - {1'b0, opb};
  end

  // Accumulator, held operand and mode; loaded at start, advanced once per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opb      <= '0;
      mode_div <= 1'b0;
    end else if (load) begin
      // Multiply shifts the multiplier out of the bottom; divide shifts the
      // dividend out of the top of the lower half.
      acc      <= {{W{1'b0}}, (is_div ? a : b)};
      opb      <= is_div ? b : a;
      mode_div <= is_div;
    end else if (step) begin
      if (!mode_div) begin
        acc <= {mul_sum, acc[W-1:1]};
      end else if (!div_trial[W]) begin
        acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Handshake: start is sampled only in IDLE with a valid op and no flush;
// busy is high from the cycle after acceptance through the FIX cycle;
// done pulses for one cycle when HI/LO have just been written. All outputs
// come straight from registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MDUOP_WIDTH-1:0] mdu_op,
  input  logic [W-1:0]           op1,
  input  logic [W-1:0]           op2,
  input  logic                   flush,
  input  logic                   wr_hi,
  input  logic                   wr_lo,
  input  logic [W-1:0]           wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           hi,
  output logic [W-1:0]           lo,
  output logic                   div_by_zero
);

  mdu_state_t     state, state_nxt;
  logic           load, step, fix_wr;
  logic [CNT_W-1:0] cnt;
  logic           is_div_q, res_neg, rem_neg, dbz_pend;
  logic [W-1:0]   op1_raw;
  logic           op_is_div, op_is_signed;
  logic [W-1:0]   a_abs, b_abs;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  // Operand decode and magnitudes for the unsigned core.
  always_comb begin
    op_is_div    = (mdu_op == MDU_OP_DIV) || (mdu_op == MDU_OP_DIVU);
    op_is_signed = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_DIV);
    a_abs        = (op_is_signed && op1[W-1]) ? -op1 : op1;
    b_abs        = (op_is_signed && op2[W-1]) ? -op2 : op2;
  end

  mdu_iter_core #(.W(W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op_is_div),
    .a      (a_abs),
    .b      (b_abs),
    .acc    (acc)
  );

  // Sign correction of the raw magnitude results.
  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quot_fix = res_neg ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MDU_IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath controls; flush wins over every transition.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix_wr    = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start && mdu_op_valid(mdu_op) && !flush) begin
          load      = 1'b1;
          state_nxt = MDU_CALC;
        end
      end
      MDU_CALC: begin
        step = 1'b1;
        if (flush)                   state_nxt = MDU_IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = MDU_FIX;
      end
      MDU_FIX: begin
        state_nxt = MDU_IDLE;
        fix_wr    = !flush;
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  // Per-operation context captured at acceptance, plus the iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dbz_pend <= 1'b0;
      op1_raw  <= '0;
    end else if (load) begin
      cnt      <= CNT_W'(W);
      is_div_q <= op_is_div;
      res_neg  <= op_is_signed && (op1[W-1] ^ op2[W-1]);
      rem_neg  <= op_is_signed && op_is_div && op1[W-1];
      dbz_pend <= op_is_div && (op2 == '0);
      op1_raw  <= op1;
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // HI/LO: MTHI/MTLO only while idle, result write from FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      if (!is_div_q) begin
        {hi, lo} <= prod_fix;
      end else if (dbz_pend) begin
        hi <= op1_raw;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quot_fix;
      end
    end else if (state == MDU_IDLE) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

  // Handshake outputs and the sticky divide-by-zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fix_wr;
      if (load)        div_by_zero <= 1'b0;
      else if (fix_wr) div_by_zero <= dbz_pend;
    end
  end

  assign busy = (state != MDU_IDLE);

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu at W=32: a table of operations with hand-computed
// HI/LO/flag results and latency, plus sequences for MTHI/MTLO, ignored
// starts, flush in CALC and FIX, stale writes and asynchronous reset.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic                   clk, rst_n, start, flush, wr_hi, wr_lo;
  logic [MDUOP_WIDTH-1:0] mdu_op;
  logic [W-1:0]           op1, op2, wr_data;
  logic                   busy, done, div_by_zero;
  logic [W-1:0]           hi, lo;

  mdu #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mdu_op      (mdu_op),
    .op1         (op1),
    .op2         (op2),
    .flush       (flush),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [MDUOP_WIDTH-1:0] op;
    logic [W-1:0]           a;
    logic [W-1:0]           b;
    logic [W-1:0]           exp_hi;
    logic [W-1:0]           exp_lo;
    logic                   exp_dbz;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  // Issue one start, optionally pulse wr_lo or flush at sample index k, and
  // sample #1 after every edge until done (bounded). lat = sample index at
  // which done was seen (-1 if never); busy_cnt = samples with busy high.
  task automatic run_op(input logic [MDUOP_WIDTH-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int wr_at, input int flush_at,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    mdu_op = op; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      wr_lo = (k == wr_at);
      wr_data = 32'hDEAD_BEEF;
      flush = (k == flush_at);
      @(posedge clk); #1;
    end
    wr_lo = 1'b0;
    flush = 1'b0;
  endtask

  int lat, bcnt;

  initial begin
    rst_n = 1'b0; start = 1'b0; mdu_op = MDU_OP_NONE; op1 = '0; op2 = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;

    vecs[0]  = '{MDU_OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{MDU_OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4]  = '{MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{MDU_OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{MDU_OP_MULT,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0};
    vecs[7]  = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[8]  = '{MDU_OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{MDU_OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{MDU_OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[11] = '{MDU_OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[12] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[13] = '{MDU_OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;

    // MTHI+MTLO together, then MTHI alone.
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_lo = 1'b0; wr_data = 32'hAAAA_5555;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mt_both_lo", lo, 32'h1234_5678);
    check("mt_hi_only_hi", hi, 32'hAAAA_5555);

    // Invalid op and start+flush in IDLE are both dropped.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd6; op1 = 32'd3; op2 = 32'd4;
    @(negedge clk);
    check("invalid_op_busy", busy, 0);
    mdu_op = MDU_OP_MULT; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", busy, 0);
    check("dropped_hi", hi, 32'hAAAA_5555);

    // Table of operations.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, LAT);
      check($sformatf("v%0d_busy_cycles", i), bcnt, LAT);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // wr_lo while busy is ignored.
    run_op(MDU_OP_MULT, 32'd3, 32'd4, 5, -1, lat, bcnt);
    check("stale_wr_latency", lat, LAT);
    check("stale_wr_lo", lo, 32'h0000_000C);

    // Flush 10 cycles into CALC: busy drops next cycle, no done, HI/LO kept.
    run_op(MDU_OP_DIVU, 32'd100, 32'd7, -1, 10, lat, bcnt);
    check("flush_calc_no_done", lat, -1);
    check("flush_calc_busy_cycles", bcnt, 11);
    check("flush_calc_hi", hi, 0);
    check("flush_calc_lo", lo, 32'h0000_000C);

    // Flush during FIX beats completion.
    run_op(MDU_OP_MULT, 32'hFFFF_FFFF, 32'd2, -1, LAT - 1, lat, bcnt);
    check("flush_fix_no_done", lat, -1);
    check("flush_fix_busy_cycles", bcnt, LAT);
    check("flush_fix_hi", hi, 0);
    check("flush_fix_lo", lo, 32'h0000_000C);

    // Back to back after a flush still works.
    run_op(MDU_OP_DIVU, 32'd9, 32'd0, -1, -1, lat, bcnt);
    check("post_flush_latency", lat, LAT);
    check("post_flush_lo", lo, 32'hFFFF_FFFF);
    check("post_flush_dbz", div_by_zero, 1);

    // Asynchronous reset mid-CALC clears outputs before the next edge.
    @(negedge clk);
    mdu_op = MDU_OP_MULT; op1 = 32'hFFFF_FFFF; op2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_hi", hi, 0);
    check("async_reset_lo", lo, 0);
    check("async_reset_dbz", div_by_zero, 0);
    check("async_reset_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
